// File: rtl/eth_tx_scheduler.sv
// Round-robin scheduler sharing one Ethernet/IP/UDP TX header builder among N_REQ sources.
// Latches a stable header-field set per frame, runs a done watchdog and enforces an inter-frame gap.
module eth_tx_scheduler #(
  parameter int unsigned      N_REQ          = 3,
  parameter logic [N_REQ-1:0] PEER_MASK      = 3'b110,
  parameter int unsigned      IFG_CYCLES     = 12,
  parameter int unsigned      TIMEOUT_CYCLES = 4096
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  input  logic [47:0]      BOARD_MAC,
  input  logic [31:0]      BOARD_IP,
  input  logic [15:0]      BOARD_PORT,
  input  logic [47:0]      PC_MAC,
  input  logic [31:0]      PC_IP,
  input  logic [15:0]      PC_PORT,
  output logic [47:0]      hdr_src_mac,
  output logic [31:0]      hdr_src_ip,
  output logic [15:0]      hdr_src_port,
  output logic [47:0]      hdr_dst_mac,
  output logic [31:0]      hdr_dst_ip,
  output logic [15:0]      hdr_dst_port,
  output logic [2:0]       hdr_sel,
  output logic             tx_start,
  input  logic             tx_done,
  output logic             busy,
  output logic             timeout_err,
  output logic [N_REQ-1:0] dropped
);

  localparam int unsigned PtrW   = $clog2(N_REQ);
  localparam int unsigned CntMax = (TIMEOUT_CYCLES > IFG_CYCLES) ? TIMEOUT_CYCLES : IFG_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast     = CntW'(IFG_CYCLES - 1);
  localparam logic [PtrW-1:0] PtrLast     = PtrW'(N_REQ - 1);

  typedef enum logic [2:0] {StIdle, StLatch, StStart, StWaitDone, StGap} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   rr_q, rr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [PtrW-1:0]   sel_q;
  logic              peer_ok;
  logic [N_REQ-1:0]  eligible;
  logic              win_found;
  logic [PtrW-1:0]   win_idx;

  function automatic logic [PtrW-1:0] wrap_add(logic [PtrW-1:0] base, int unsigned off);
    int unsigned s;
    s = int'(unsigned'(base)) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return PtrW'(s);
  endfunction

  assign peer_ok  = (PC_MAC != '1) && (PC_IP != '1) && (PC_PORT != '1);
  assign eligible = req & (~PEER_MASK | {N_REQ{peer_ok}});
  assign hdr_sel  = 3'(sel_q);

  // First eligible source at or after the round-robin pointer.
  always_comb begin
    logic [PtrW-1:0] idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = wrap_add(rr_q, unsigned'(k));
      if (!win_found && eligible[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (aclr) begin
      state_q <= StIdle;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d = StLatch;
          rr_d    = (win_idx == PtrLast) ? '0 : win_idx + 1'b1;
        end
      end
      StLatch: state_d = StStart;
      StStart: begin
        state_d = StWaitDone;
        cnt_d   = '0;
      end
      StWaitDone: begin
        // tx_done takes priority over a coinciding watchdog expiry.
        if (tx_done || (cnt_q == TimeoutLast)) begin
          state_d = StGap;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    grant       = '0;
    dropped     = '0;
    tx_start    = 1'b0;
    timeout_err = 1'b0;
    busy        = (state_q != StIdle);
    if (!aclr) begin
      unique case (state_q)
        StIdle: begin
          grant   = win_found ? (N_REQ'(1) << win_idx) : '0;
          dropped = req & PEER_MASK & {N_REQ{~peer_ok}};
        end
        StStart:    tx_start    = 1'b1;
        StWaitDone: timeout_err = ~tx_done & (cnt_q == TimeoutLast);
        default: ;
      endcase
    end
  end

  // Header fields stay frozen between LATCH states.
  always_ff @(posedge clock) begin
    if (aclr) begin
      sel_q        <= '0;
      hdr_src_mac  <= '0;
      hdr_src_ip   <= '0;
      hdr_src_port <= '0;
      hdr_dst_mac  <= '0;
      hdr_dst_ip   <= '0;
      hdr_dst_port <= '0;
    end else begin
      if (state_q == StIdle && win_found) sel_q <= win_idx;
      if (state_q == StLatch) begin
        hdr_src_mac  <= BOARD_MAC;
        hdr_src_ip   <= BOARD_IP;
        hdr_src_port <= BOARD_PORT;
        if (PEER_MASK[sel_q]) begin
          hdr_dst_mac  <= PC_MAC;
          hdr_dst_ip   <= PC_IP;
          hdr_dst_port <= PC_PORT;
        end else begin
          hdr_dst_mac  <= '1;
          hdr_dst_ip   <= 32'hFFFF_FFFF;
          hdr_dst_port <= BOARD_PORT;
        end
      end
    end
  end

endmodule
